traffic_input_conditioner: RTL and testbench
============================================

TRAFFIC_INPUT_CONDITIONER -- requirements
Module: traffic_input_conditioner

Interface
REQ-001 Parameter CLK_HZ, default 100000000, SHALL give the clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000 (10 ms), SHALL give the consecutive-cycle stability required before a debounced level changes; legal range 2 and up.
REQ-003 Parameter TICK_DIV, default CLK_HZ, SHALL give the clock cycles per tick period; legal range 2 and up.
REQ-004 clock  input  1  single system clock, all state on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 walk  input  1  raw pedestrian button, asynchronous and bouncing.
REQ-007 sensor  input  1  raw side-street vehicle sensor, asynchronous and bouncing.
REQ-008 walk_ack  input  1  from traffic_light_fsm: a walk phase has been granted.
REQ-009 walk_req  output  1  registered, latched pedestrian request to traffic_light_fsm.
REQ-010 sensor_active  output  1  registered, debounced sensor level.
REQ-011 tick  output  1  registered, one-cycle timebase strobe, every TICK_DIV cycles.

Function
REQ-012 Each of walk and sensor SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-013 Debouncer: count mismatching cycles while synced input differs from the stable level. Clear the count on any matching cycle. Toggle the stable level and clear the count on the cycle the count would reach DEBOUNCE_CYCLES.
REQ-014 A clean input transition SHALL appear on the debounced level exactly DEBOUNCE_CYCLES+2 rising edges later, and on sensor_active on that same edge.
REQ-015 Glitches shorter than DEBOUNCE_CYCLES synced cycles SHALL never change a debounced level.
REQ-016 Walk request FSM states: W_IDLE, W_PEND, W_HELD.
REQ-017 W_IDLE to W_PEND on a debounced walk rising edge; walk_req rises on the following edge (DEBOUNCE_CYCLES+3 after press).
REQ-018 W_PEND holds walk_req=1 until walk_ack is sampled high. Then go to W_HELD if debounced walk is still 1, else to W_IDLE; walk_req=0 from that edge.
REQ-019 W_HELD to W_IDLE when debounced walk falls; a held button SHALL never re-raise walk_req.
REQ-020 When a debounced rising edge and walk_ack coincide in W_IDLE, the request SHALL be taken (go to W_PEND); walk_ack outside W_PEND is ignored.
REQ-021 Tick counter, width $clog2(TICK_DIV), counts 0 to TICK_DIV-1 and wraps to 0. tick=1 for exactly the one cycle after the counter holds TICK_DIV-1.
REQ-022 The tick counter SHALL free-run, independent of inputs and walk_ack.

Reset
REQ-023 While reset is high: synchronizers, stable levels, debounce counters and tick counter = 0; FSM = W_IDLE; walk_req = sensor_active = tick = 0.
REQ-024 Reset asserted mid-operation SHALL discard any pending request and partial debounce count. After release, the first tick SHALL occur TICK_DIV edges later.

Structure
REQ-025 The shared package traffic_pkg SHALL hold the walk-FSM state enum and the default CLK_HZ, DEBOUNCE_CYCLES and TICK_DIV constants.
REQ-026 Synchronizer plus debouncer SHALL be the sub-module input_debouncer (parameter DEBOUNCE_CYCLES), instantiated once for walk and once for sensor.
REQ-027 The FSM and tick divider SHALL live in the top module.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=8)
REQ-028 Reset pulse, then idle 20 cycles: tick high on edges 8 and 16 after release only; walk_req = sensor_active = 0 throughout.
REQ-029 sensor 0 to 1 clean: sensor_active rises exactly 6 edges later. Sensor pulses of 1, 2 and 3 cycles: sensor_active stays 0.
REQ-030 walk held high 20 cycles: walk_req rises 7 edges after press. walk_ack pulsed once at cycle 12: walk_req falls next edge and stays 0 while the button is held. Release, then press again: walk_req rises again.
REQ-031 walk bouncing 1-cycle toggles for 10 cycles, then steady 1: exactly one walk_req assertion.
REQ-032 walk_req=1 with reset asserted asynchronously mid-cycle: walk_req = 0 immediately without a clock edge. After release, no request until a new debounced press.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg: walk-request FSM states and default timing constants for the traffic input path
package traffic_pkg;
    typedef enum logic [1:0] {W_IDLE, W_PEND, W_HELD} walk_state_t;
    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEF_TICK_DIV = DEF_CLK_HZ;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchronizer followed by a consecutive-mismatch debouncer
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic mismatch, done;
    assign mismatch = sync[1] != level;
    // The level flips on the edge where the count would reach DEBOUNCE_CYCLES.
    assign done = mismatch && cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[0], din};
            cnt   <= (mismatch && !done) ? cnt + 1'b1 : '0;
            level <= level ^ done;
        end
    end
endmodule

// File: rtl/traffic_input_conditioner.sv
// traffic_input_conditioner: debounced walk/sensor inputs, latched walk request and tick timebase
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int CLK_HZ          = DEF_CLK_HZ,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = CLK_HZ
) (
    input  logic clock,
    input  logic reset,
    input  logic walk,
    input  logic sensor,
    input  logic walk_ack,
    output logic walk_req,
    output logic sensor_active,
    output logic tick
);
    localparam int TW = $clog2(TICK_DIV);
    walk_state_t state, next;
    logic walk_lvl, walk_prev, walk_rise, wrap;
    logic [TW-1:0] tcnt;
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_walk (
        .clock(clock), .reset(reset), .din(walk), .level(walk_lvl)
    );
    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor (
        .clock(clock), .reset(reset), .din(sensor), .level(sensor_active)
    );
    assign walk_rise = walk_lvl && !walk_prev;
    assign wrap = tcnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= W_IDLE;
            walk_prev <= 1'b0;
            walk_req  <= 1'b0;
            tcnt      <= '0;
            tick      <= 1'b0;
        end else begin
            state     <= next;
            walk_prev <= walk_lvl;
            walk_req  <= next == W_PEND;
            tcnt      <= wrap ? '0 : tcnt + 1'b1;
            tick      <= wrap;
        end
    end
    // A held button parks in W_HELD so it cannot re-raise the request.
    always_comb begin
        next = state;
        if (state == W_IDLE && walk_rise)
            next = W_PEND;
        else if (state == W_PEND && walk_ack)
            next = walk_lvl ? W_HELD : W_IDLE;
        else if (state == W_HELD && !walk_lvl)
            next = W_IDLE;
    end
endmodule

// File: tb/tb_traffic_input_conditioner.sv
// tb_traffic_input_conditioner: table, directed and randomized checks against a window-based reference model
module tb_traffic_input_conditioner;
    localparam int D = 4;
    localparam int TD = 8;
    typedef struct {
        logic w, s, a, req, act, tk;
    } vec_t;
    logic clk = 1'b0, reset = 1'b0, walk = 1'b0, sensor = 1'b0, walk_ack = 1'b0;
    logic walk_req, sensor_active, tick;
    int checks = 0, errors = 0;
    vec_t tbl [28];
    logic [D+1:0] hw, hs;
    logic mw, ms, rose_last, pend, mtick;
    int edges;

    traffic_input_conditioner #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
        .clock(clk), .reset(reset), .walk(walk), .sensor(sensor), .walk_ack(walk_ack),
        .walk_req(walk_req), .sensor_active(sensor_active), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // True when the synced samples of the last D edges all disagree with the current level.
    function automatic bit all_differ(input logic [D+1:0] h, input logic l);
        return l ? (h[D+1:2] == '0) : (&h[D+1:2]);
    endfunction

    // Reference model: raw history window, pending-request flag, edge counter since reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hw = '0; hs = '0; mw = 0; ms = 0; rose_last = 0; pend = 0; mtick = 0; edges = 0;
        end else begin
            edges++;
            if (pend && walk_ack) pend = 0;
            else if (!pend && rose_last) pend = 1;
            hw = {hw[D:0], walk};
            hs = {hs[D:0], sensor};
            rose_last = 0;
            if (all_differ(hw, mw)) begin
                mw = !mw;
                rose_last = mw;
            end
            if (all_differ(hs, ms)) ms = !ms;
            mtick = (edges % TD) == 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_walk_req", walk_req, pend);
            chk("model_sensor_active", sensor_active, ms);
            chk("model_tick", tick, mtick);
        end
    end

    task automatic cyc(input logic w, input logic s, input logic a);
        walk = w;
        sensor = s;
        walk_ack = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen, rises;
        logic prev;
        for (int r = 0; r < 28; r++)
            tbl[r] = '{w: 0, s: (r >= 20), a: 0, req: 0, act: (r >= 25), tk: ((r + 1) % TD == 0)};
        #2 reset = 1'b1;
        #1;
        chk("reset_walk_req", walk_req, 0);
        chk("reset_sensor_active", sensor_active, 0);
        chk("reset_tick", tick, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int r = 0; r < 28; r++) begin
            cyc(tbl[r].w, tbl[r].s, tbl[r].a);
            chk($sformatf("tbl%0d_walk_req", r), walk_req, tbl[r].req);
            chk($sformatf("tbl%0d_sensor_active", r), sensor_active, tbl[r].act);
            chk($sformatf("tbl%0d_tick", r), tick, tbl[r].tk);
        end
        repeat (8) cyc(0, 0, 0);
        chk("sensor_fall", sensor_active, 0);
        for (int len = 1; len <= 3; len++) begin
            seen = 0;
            repeat (len) begin cyc(0, 1, 0); seen |= sensor_active; end
            repeat (8) begin cyc(0, 0, 0); seen |= sensor_active; end
            chk($sformatf("glitch%0d_sensor_active", len), seen, 0);
        end
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 0, i == 12);
            chk($sformatf("hold%0d_walk_req", i), walk_req, (i >= 7 && i < 12));
        end
        repeat (10) begin cyc(0, 0, 0); chk("release_walk_req", walk_req, 0); end
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("repress%0d_walk_req", i), walk_req, i >= 7);
        end
        cyc(1, 0, 1);
        chk("repress_ack_walk_req", walk_req, 0);
        repeat (10) cyc(0, 0, 0);
        rises = 0;
        prev = walk_req;
        for (int i = 0; i < 30; i++) begin
            cyc(i >= 10 || i % 2 == 0, 0, 0);
            if (walk_req && !prev) rises++;
            prev = walk_req;
        end
        chk("bounce_rises", rises, 1);
        chk("pre_reset_walk_req", walk_req, 1);
        walk = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_reset_walk_req", walk_req, 0);
        chk("async_reset_sensor_active", sensor_active, 0);
        chk("async_reset_tick", tick, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 0);
            chk($sformatf("post_reset%0d_walk_req", i), walk_req, 0);
            chk($sformatf("post_reset%0d_tick", i), tick, (i % TD) == 0);
        end
        for (int i = 1; i <= 8; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("new_press%0d_walk_req", i), walk_req, i >= 7);
        end
        cyc(1, 0, 1);
        repeat (8) cyc(0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) walk = !walk;
            if ($urandom_range(0, 4) == 0) sensor = !sensor;
            walk_ack = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3 reset = 1'b1;
                #4 reset = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
